sram_slot_sched: RTL

Cycle-slot scheduler for the card's external SRAM port. It splits every 6502 bus cycle into two SRAM access slots. The 6502 slot path (register-window RAM accesses) gets the late slot whenever it requests it. A background fill/copy engine uses every other slot. It sits between the bus-phase state counter and the SRAM control pins, replacing direct RAMSEL-driven chip selects.

---
 rtl/sram_slot_sched_if.sv | 39 +++
 rtl/sram_slot_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sram_slot_sched_if.sv
// Port bundle for sram_slot_sched: bus-phase input, host window, engine
// control and the SRAM pins.
interface sram_slot_sched_if #(
  parameter int AW = 20,
  parameter int LW = 16
);
  logic [2:0]    S;
  logic          HostReq;
  logic [AW-1:0] HostAddr;
  logic          HostnWE;
  logic          Start;
  logic          Copy;
  logic [AW-1:0] SrcAddr;
  logic [AW-1:0] DstAddr;
  logic [LW-1:0] Len;
  logic [7:0]    FillData;
  logic [7:0]    MemDin;
  logic [AW-1:0] MemA;
  logic          MemnCS;
  logic          MemnOE;
  logic          MemnWE;
  logic [7:0]    MemDout;
  logic          MemDOE;
  logic          HostGnt;
  logic          Busy;
  logic          Done;

  modport master (
    output S, HostReq, HostAddr, HostnWE, Start, Copy, SrcAddr, DstAddr,
           Len, FillData, MemDin,
    input  MemA, MemnCS, MemnOE, MemnWE, MemDout, MemDOE, HostGnt, Busy, Done
  );

  modport slave (
    input  S, HostReq, HostAddr, HostnWE, Start, Copy, SrcAddr, DstAddr,
           Len, FillData, MemDin,
    output MemA, MemnCS, MemnOE, MemnWE, MemDout, MemDOE, HostGnt, Busy, Done
  );
endinterface

// File: rtl/sram_slot_sched.sv
// SRAM slot scheduler: slot A (S1..S3) always serves the fill/copy engine,
// slot B (S4..S7) serves the host when requested, otherwise the engine.
module sram_slot_sched #(
  parameter int AW = 20,
  parameter int LW = 16
) (
  input logic              C7M,
  input logic              RES,
  sram_slot_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } eng_state_t;

  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] ONE_L = {{(LW-1){1'b0}}, 1'b1};

  eng_state_t    state_r;
  eng_state_t    state_nx_s;
  logic [AW-1:0] src_r;
  logic [AW-1:0] dst_r;
  logic [LW-1:0] cnt_r;
  logic [7:0]    buf_r;
  logic [7:0]    fill_r;
  logic          copy_r;
  logic          done_r;
  logic          gnt_r;
  logic          act_a_r;
  logic          act_b_r;

  logic          busy_s;
  logic          start_s;
  logic          len_zero_s;
  logic          eng_b_s;
  logic          bk_s;
  logic          last_s;
  logic          eng_rd_s;
  logic          eng_k_s;
  logic          eng_k1_s;
  logic          eng_k2_s;
  logic          host_s;
  logic          host_cs_s;
  logic [AW-1:0] eng_addr_s;

  assign busy_s     = (state_r != ST_IDLE);
  assign start_s    = bus.Start && !busy_s;
  assign len_zero_s = (bus.Len == {LW{1'b0}});
  // Engine owns slot B only if busy at S4 and the host was not granted at S3.
  assign eng_b_s    = busy_s && !gnt_r;
  assign bk_s       = ((bus.S == 3'd3) && act_a_r) || ((bus.S == 3'd6) && act_b_r);
  assign last_s     = (cnt_r == ONE_L);
  assign eng_rd_s   = (state_r == ST_RD);
  assign eng_addr_s = eng_rd_s ? src_r : dst_r;

  // Slot phase decode: k = address setup, k+1 = strobe, k+2 = hold/capture.
  assign eng_k_s   = ((bus.S == 3'd1) && busy_s) || ((bus.S == 3'd4) && eng_b_s);
  assign eng_k1_s  = ((bus.S == 3'd2) && act_a_r) || ((bus.S == 3'd5) && act_b_r);
  assign eng_k2_s  = ((bus.S == 3'd3) && act_a_r) || ((bus.S == 3'd6) && act_b_r);
  assign host_s    = gnt_r && (bus.S >= 3'd4);
  assign host_cs_s = host_s && (bus.S != 3'd4);

  assign bus.MemA    = (eng_k_s || eng_k1_s || eng_k2_s) ? eng_addr_s :
                       (host_s ? bus.HostAddr : {AW{1'b0}});
  assign bus.MemnCS  = !(eng_k1_s || eng_k2_s || host_cs_s);
  assign bus.MemnOE  = !(((eng_k1_s || eng_k2_s) && eng_rd_s) || (host_cs_s && bus.HostnWE));
  assign bus.MemnWE  = !((eng_k1_s && !eng_rd_s) ||
                         (host_s && ((bus.S == 3'd5) || (bus.S == 3'd6)) && !bus.HostnWE));
  assign bus.MemDOE  = (eng_k1_s || eng_k2_s) && !eng_rd_s;
  assign bus.MemDout = copy_r ? buf_r : fill_r;
  assign bus.HostGnt = host_s;
  assign bus.Busy    = busy_s;
  assign bus.Done    = done_r;

  // Engine next-state: moves only on a bookkeeping edge or an accepted Start.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s && !len_zero_s) begin
          state_nx_s = bus.Copy ? ST_RD : ST_WR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (bk_s) begin
          state_nx_s = ST_WR;
        end else begin
          state_nx_s = ST_RD;
        end
      end
      ST_WR: begin
        if (bk_s && last_s) begin
          state_nx_s = ST_IDLE;
        end else if (bk_s && copy_r) begin
          state_nx_s = ST_RD;
        end else begin
          state_nx_s = ST_WR;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Engine state register.
  always_ff @(posedge C7M) begin
    if (RES) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Slot ownership, transfer registers and completion pulse.
  always_ff @(posedge C7M) begin
    if (RES) begin
      src_r   <= {AW{1'b0}};
      dst_r   <= {AW{1'b0}};
      cnt_r   <= {LW{1'b0}};
      buf_r   <= 8'h00;
      fill_r  <= 8'h00;
      copy_r  <= 1'b0;
      done_r  <= 1'b0;
      gnt_r   <= 1'b0;
      act_a_r <= 1'b0;
      act_b_r <= 1'b0;
    end else begin
      done_r <= 1'b0;

      case (bus.S)
        3'd3:                gnt_r <= bus.HostReq;
        3'd4, 3'd5, 3'd6:    gnt_r <= gnt_r;
        default:             gnt_r <= 1'b0;
      endcase

      // An out-of-sequence S drops any half-open slot; the engine holds.
      case (bus.S)
        3'd1:    act_a_r <= busy_s;
        3'd2:    act_a_r <= act_a_r;
        default: act_a_r <= 1'b0;
      endcase

      case (bus.S)
        3'd4:    act_b_r <= eng_b_s;
        3'd5:    act_b_r <= act_b_r;
        default: act_b_r <= 1'b0;
      endcase

      if (start_s) begin
        if (len_zero_s) begin
          done_r <= 1'b1;
        end else begin
          src_r  <= bus.SrcAddr;
          dst_r  <= bus.DstAddr;
          cnt_r  <= bus.Len;
          fill_r <= bus.FillData;
          copy_r <= bus.Copy;
        end
      end else if (bk_s && (state_r == ST_RD)) begin
        buf_r <= bus.MemDin;
        src_r <= src_r + ONE_A;
      end else if (bk_s && (state_r == ST_WR)) begin
        dst_r <= dst_r + ONE_A;
        cnt_r <= cnt_r - ONE_L;
        done_r <= last_s;
      end else begin
        src_r <= src_r;
      end
    end
  end

endmodule
